// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request/response and data-memory signal bundle for mem_access_unit
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        stall;
    logic [31:0] mem_address;
    logic [31:0] mem_datain;
    logic        mem_memwrite;
    logic        mem_memread;
    logic [31:0] mem_frommemory;

    // The unit itself: takes requests and memory read data, drives everything else.
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, mem_frommemory,
        output req_ready, resp_valid, resp_rdata, resp_err, stall,
        output mem_address, mem_datain, mem_memwrite, mem_memread
    );

    // The execute stage plus data memory around the unit.
    modport master (
        output req_valid, req_write, req_addr, req_wdata, mem_frommemory,
        input  req_ready, resp_valid, resp_rdata, resp_err, stall,
        input  mem_address, mem_datain, mem_memwrite, mem_memread
    );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store access controller for the word-addressed data memory
module mem_access_unit #(
    parameter int MEM_WORDS = 32,
    parameter int MEM_LAT   = 2
) (
    input  logic            clk,
    input  logic            rst,
    mem_access_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [3:0]  lat_cnt, lat_cnt_n;

    // Output registers; the latched request lives in the memory-side registers
    // while ACCESS is active, so no separate copy is kept.
    logic [31:0] mem_address_q, mem_address_n;
    logic [31:0] mem_datain_q, mem_datain_n;
    logic        mem_memwrite_q, mem_memwrite_n;
    logic        mem_memread_q, mem_memread_n;
    logic        resp_valid_q, resp_valid_n;
    logic [31:0] resp_rdata_q, resp_rdata_n;
    logic        resp_err_q, resp_err_n;

    logic        accept;
    logic        addr_bad;

    assign accept   = (state == IDLE) && bus.req_valid && !rst;
    assign addr_bad = (bus.req_addr[1:0] != 2'b00) ||
                      ({2'b00, bus.req_addr[31:2]} >= 32'(MEM_WORDS));

    // State, latency counter and every registered output; reset clears all of them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            lat_cnt        <= 4'd0;
            mem_address_q  <= 32'd0;
            mem_datain_q   <= 32'd0;
            mem_memwrite_q <= 1'b0;
            mem_memread_q  <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_rdata_q   <= 32'd0;
            resp_err_q     <= 1'b0;
        end else begin
            state          <= state_n;
            lat_cnt        <= lat_cnt_n;
            mem_address_q  <= mem_address_n;
            mem_datain_q   <= mem_datain_n;
            mem_memwrite_q <= mem_memwrite_n;
            mem_memread_q  <= mem_memread_n;
            resp_valid_q   <= resp_valid_n;
            resp_rdata_q   <= resp_rdata_n;
            resp_err_q     <= resp_err_n;
        end
    end

    // Next state and next register values; outputs default to 0 so they are only
    // nonzero in the state that owns them.
    always_comb begin
        state_n        = state;
        lat_cnt_n      = lat_cnt;
        mem_address_n  = 32'd0;
        mem_datain_n   = 32'd0;
        mem_memwrite_n = 1'b0;
        mem_memread_n  = 1'b0;
        resp_valid_n   = 1'b0;
        resp_rdata_n   = 32'd0;
        resp_err_n     = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (addr_bad) begin
                        state_n    = RESP;
                        resp_valid_n = 1'b1;
                        resp_err_n   = 1'b1;
                    end else begin
                        state_n        = ACCESS;
                        lat_cnt_n      = 4'(MEM_LAT - 1);
                        mem_address_n  = {2'b00, bus.req_addr[31:2]};
                        mem_datain_n   = bus.req_wdata;
                        mem_memwrite_n = bus.req_write;
                        mem_memread_n  = !bus.req_write;
                    end
                end
            end
            ACCESS: begin
                if (lat_cnt == 4'd0) begin
                    state_n      = RESP;
                    resp_valid_n = 1'b1;
                    resp_rdata_n = mem_memwrite_q ? 32'd0 : bus.mem_frommemory;
                end else begin
                    lat_cnt_n      = lat_cnt - 4'd1;
                    mem_address_n  = mem_address_q;
                    mem_datain_n   = mem_datain_q;
                    mem_memwrite_n = mem_memwrite_q;
                    mem_memread_n  = mem_memread_q;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.req_ready    = (state == IDLE) && !rst;
    assign bus.stall        = (state == ACCESS) || ((state == IDLE) && bus.req_valid && !rst);
    assign bus.mem_address  = mem_address_q;
    assign bus.mem_datain   = mem_datain_q;
    assign bus.mem_memwrite = mem_memwrite_q;
    assign bus.mem_memread  = mem_memread_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_rdata   = resp_rdata_q;
    assign bus.resp_err     = resp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

    logic clk;
    logic rst;
    int   tests;
    int   failed;

    mem_access_unit_if bus ();

    mem_access_unit #(
        .MEM_WORDS(32),
        .MEM_LAT  (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Every output at its idle value; req_ready and stall are passed in.
    task automatic check_quiet(input string tag, input logic rdy, input logic stl);
        check({tag, " req_ready"},    32'(bus.req_ready),    32'(rdy));
        check({tag, " stall"},        32'(bus.stall),        32'(stl));
        check({tag, " resp_valid"},   32'(bus.resp_valid),   32'd0);
        check({tag, " resp_rdata"},   bus.resp_rdata,        32'd0);
        check({tag, " resp_err"},     32'(bus.resp_err),     32'd0);
        check({tag, " mem_address"},  bus.mem_address,       32'd0);
        check({tag, " mem_datain"},   bus.mem_datain,        32'd0);
        check({tag, " mem_memwrite"}, 32'(bus.mem_memwrite), 32'd0);
        check({tag, " mem_memread"},  32'(bus.mem_memread),  32'd0);
    endtask

    task automatic check_access(input string tag, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata);
        check({tag, " mem_memwrite"}, 32'(bus.mem_memwrite), 32'(wr));
        check({tag, " mem_memread"},  32'(bus.mem_memread),  32'(!wr));
        check({tag, " mem_address"},  bus.mem_address,       addr);
        check({tag, " mem_datain"},   bus.mem_datain,        wdata);
        check({tag, " req_ready"},    32'(bus.req_ready),    32'd0);
        check({tag, " stall"},        32'(bus.stall),        32'd1);
        check({tag, " resp_valid"},   32'(bus.resp_valid),   32'd0);
    endtask

    task automatic check_resp(input string tag, input logic err, input logic [31:0] rdata);
        check({tag, " resp_valid"},   32'(bus.resp_valid),   32'd1);
        check({tag, " resp_err"},     32'(bus.resp_err),     32'(err));
        check({tag, " resp_rdata"},   bus.resp_rdata,        rdata);
        check({tag, " req_ready"},    32'(bus.req_ready),    32'd0);
        check({tag, " stall"},        32'(bus.stall),        32'd0);
        check({tag, " mem_memwrite"}, 32'(bus.mem_memwrite), 32'd0);
        check({tag, " mem_memread"},  32'(bus.mem_memread),  32'd0);
        check({tag, " mem_address"},  bus.mem_address,       32'd0);
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        #1;
        check("issue req_ready", 32'(bus.req_ready), 32'd1);
        check("issue stall",     32'(bus.stall),     32'd1);
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        rst = 1'b1;
        bus.req_valid      = 1'b0;
        bus.req_write      = 1'b0;
        bus.req_addr       = 32'd0;
        bus.req_wdata      = 32'd0;
        bus.mem_frommemory = 32'd0;

        // 1: reset held for three edges, then released
        repeat (3) @(negedge clk);
        check_quiet("reset", 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check_quiet("post_reset", 1'b1, 1'b0);

        // 2: store 0x2 to byte 0x0C (word 3)
        @(negedge clk);
        issue(1'b1, 32'h0000_000C, 32'h0000_0002);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check_access("st T+1", 1'b1, 32'd3, 32'd2);
        @(negedge clk);
        check_access("st T+2", 1'b1, 32'd3, 32'd2);
        @(negedge clk);
        check_resp("st T+3", 1'b0, 32'd0);
        @(negedge clk);
        check_quiet("st T+4", 1'b1, 1'b0);

        // 3: load from byte 0x08 (word 2), memory returns 22
        bus.mem_frommemory = 32'd22;
        issue(1'b0, 32'h0000_0008, 32'hDEAD_BEEF);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check_access("ld T+1", 1'b0, 32'd2, 32'hDEAD_BEEF);
        @(negedge clk);
        check_access("ld T+2", 1'b0, 32'd2, 32'hDEAD_BEEF);
        @(negedge clk);
        check_resp("ld T+3", 1'b0, 32'd22);
        @(negedge clk);
        check_quiet("ld T+4", 1'b1, 1'b0);

        // 4a: misaligned load at 0x06
        issue(1'b0, 32'h0000_0006, 32'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check_resp("mis T+1", 1'b1, 32'd0);
        @(negedge clk);
        check_quiet("mis T+2", 1'b1, 1'b0);

        // 4b: out-of-range store at 0x80 (word 32)
        issue(1'b1, 32'h0000_0080, 32'h1234_5678);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check_resp("oor T+1", 1'b1, 32'd0);
        check("oor mem_datain", bus.mem_datain, 32'd0);
        @(negedge clk);
        check_quiet("oor T+2", 1'b1, 1'b0);

        // 5: req_valid held across two loads, 0x04 then 0x7C (word 31)
        bus.mem_frommemory = 32'h1111_1111;
        issue(1'b0, 32'h0000_0004, 32'd0);
        @(negedge clk);
        check_access("b2b1 T+1", 1'b0, 32'd1, 32'd0);
        @(negedge clk);
        check_access("b2b1 T+2", 1'b0, 32'd1, 32'd0);
        @(negedge clk);
        check_resp("b2b1 T+3", 1'b0, 32'h1111_1111);
        bus.req_addr = 32'h0000_007C;
        @(negedge clk);
        check("b2b idle req_ready", 32'(bus.req_ready), 32'd1);
        check("b2b idle stall",     32'(bus.stall),     32'd1);
        check("b2b idle strobe",    32'(bus.mem_memread), 32'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.mem_frommemory = 32'hCAFE_F00D;
        check_access("b2b2 T+1", 1'b0, 32'd31, 32'd0);
        @(negedge clk);
        check_access("b2b2 T+2", 1'b0, 32'd31, 32'd0);
        @(negedge clk);
        check_resp("b2b2 T+3", 1'b0, 32'hCAFE_F00D);
        @(negedge clk);
        check_quiet("b2b2 T+4", 1'b1, 1'b0);

        // 6: reset asserted during the first ACCESS cycle of a load
        bus.mem_frommemory = 32'h5555_AAAA;
        issue(1'b0, 32'h0000_0010, 32'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check_access("abort T+1", 1'b0, 32'd4, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_quiet("abort in reset", 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check("abort release req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        check_quiet("abort after", 1'b1, 1'b0);
        @(negedge clk);
        check_quiet("abort after2", 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
